// File: rtl/dm_uncached_ctrl_pkg.sv
// rtl/dm_uncached_ctrl_pkg.sv - shared constants for the uncached data-memory controller
package dm_uncached_ctrl_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/dm_uncached_ctrl_if.sv
// rtl/dm_uncached_ctrl_if.sv - SRAM-like data bus (req / addr_ok / data_ok)
interface dm_uncached_ctrl_if
   import dm_uncached_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/dm_uncached_ctrl.sv
// rtl/dm_uncached_ctrl.sv - sequences uncached MEM-stage loads/stores onto the data bus
module dm_uncached_ctrl
   import dm_uncached_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic                clk,
   input  logic                resetn,
   input  logic                mem_valid,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [1:0]          mem_size,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_uncached,
   input  logic                pipe_ready,
   input  logic                flush,
   output logic                dm_stall,
   output logic [DATA_W-1:0]   mem_rdata,
   dm_uncached_ctrl_if.master  data_sram
);

   logic [2:0]        state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              new_acc;
   logic              stall_c;
   logic [DATA_W-1:0] rdata_c;

   always_comb begin
      new_acc = mem_valid & (mem_read | mem_write) & mem_uncached & ~flush;
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      stall_c = 1'b0;
      rdata_c = rdata_q;
      case (state_q)
         S_IDLE: begin
            stall_c = new_acc;
            if (new_acc) begin
               wr_d    = mem_write;
               size_d  = mem_size;
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            stall_c = 1'b1;
            // Withdrawal before addr_ok is legal, so a flushed store never lands.
            if (data_sram.addr_ok)
               state_d = flush ? S_DRAIN : S_WAIT;
            else if (flush)
               state_d = S_IDLE;
         end
         S_WAIT: begin
            stall_c = ~data_sram.data_ok;
            if (data_sram.data_ok) begin
               rdata_c = data_sram.rdata;
               if (flush || pipe_ready) begin
                  state_d = S_IDLE;
               end else begin
                  rdata_d = data_sram.rdata;
                  state_d = S_DONE;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            if (pipe_ready || flush)
               state_d = S_IDLE;
         end
         S_DRAIN: begin
            // Younger uncached access is held off until the cancelled one retires.
            stall_c = new_acc;
            if (data_sram.data_ok)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= SZ_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign data_sram.req   = (state_q == S_REQ);
   assign data_sram.wr    = wr_q;
   assign data_sram.size  = size_q;
   assign data_sram.addr  = addr_q;
   assign data_sram.wdata = wdata_q;

   assign dm_stall  = resetn & stall_c;
   assign mem_rdata = resetn ? rdata_c : '0;

endmodule

// File: tb/tb_dm_uncached_ctrl.sv
// tb/tb_dm_uncached_ctrl.sv - scoreboard bench for dm_uncached_ctrl
module tb_dm_uncached_ctrl;
   import dm_uncached_ctrl_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk;
   logic        resetn;
   logic        mem_valid, mem_read, mem_write, mem_uncached, pipe_ready, flush;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        dm_stall;
   logic [31:0] mem_rdata;

   int   n_vec = 0;
   int   n_err = 0;
   req_t exp_req[$];
   logic [31:0] exp_rd[$];
   req_t mon_e;
   logic [31:0] mon_d;

   dm_uncached_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dm_uncached_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_valid    (mem_valid),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_uncached (mem_uncached),
      .pipe_ready   (pipe_ready),
      .flush        (flush),
      .dm_stall     (dm_stall),
      .mem_rdata    (mem_rdata),
      .data_sram    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic issue(input logic wr_i, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
      mem_valid    = 1'b1;
      mem_read     = ~wr_i;
      mem_write    = wr_i;
      mem_size     = sz;
      mem_addr     = a;
      mem_wdata    = wd;
      mem_uncached = 1'b1;
   endtask

   task automatic push_req(input logic wr_i, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
      req_t r;
      r.wr = wr_i; r.size = sz; r.addr = a; r.wdata = wd;
      exp_req.push_back(r);
   endtask

   task automatic drop();
      mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
   endtask

   // Scoreboard monitor: bus handshakes and load completions
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.req && bus.addr_ok) begin
            if (exp_req.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL bus_req: unexpected request addr %h, expected none", bus.addr);
            end else begin
               mon_e = exp_req.pop_front();
               chk("bus_wr",    64'(bus.wr),    64'(mon_e.wr));
               chk("bus_size",  64'(bus.size),  64'(mon_e.size));
               chk("bus_addr",  64'(bus.addr),  64'(mon_e.addr));
               chk("bus_wdata", 64'(bus.wdata), 64'(mon_e.wdata));
            end
         end
         if (mem_valid && mem_read && mem_uncached && !flush && pipe_ready && !dm_stall) begin
            if (exp_rd.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL load_done: unexpected completion rdata %h, expected none", mem_rdata);
            end else begin
               mon_d = exp_rd.pop_front();
               chk("load_rdata", 64'(mem_rdata), 64'(mon_d));
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; flush = 1'b0; pipe_ready = 1'b1;
      mem_size = SZ_W; mem_addr = '0; mem_wdata = '0; mem_uncached = 1'b0;
      bus.rdata = '0;
      drop();
      #1;
      issue(1'b0, SZ_W, 32'hBFD0_0000, 32'h0);
      smp();
      chk("rst_stall", 64'(dm_stall), 64'd0);
      chk("rst_req",   64'(bus.req),  64'd0);
      chk("rst_rdata", 64'(mem_rdata), 64'd0);
      chk("rst_state", 64'(dut.state_q), 64'(S_IDLE));
      nxt(); nxt();
      drop(); resetn = 1'b1;
      nxt();

      // Load word, minimum latency
      issue(1'b0, SZ_W, 32'hBFD0_0010, 32'h0);
      push_req(1'b0, SZ_W, 32'hBFD0_0010, 32'h0);
      smp(); chk("t1_c0_stall", 64'(dm_stall), 64'd1); chk("t1_c0_req", 64'(bus.req), 64'd0);
      nxt();
      bus.addr_ok = 1'b1;
      smp(); chk("t1_c1_stall", 64'(dm_stall), 64'd1); chk("t1_c1_req", 64'(bus.req), 64'd1);
      nxt();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hDEAD_BEEF;
      exp_rd.push_back(32'hDEAD_BEEF);
      smp(); chk("t1_c2_stall", 64'(dm_stall), 64'd0); chk("t1_c2_req", 64'(bus.req), 64'd0);
      nxt();
      drop();
      smp(); chk("t1_state", 64'(dut.state_q), 64'(S_IDLE)); chk("t1_c3_req", 64'(bus.req), 64'd0);
      nxt();

      // Cached access: no stall, no bus activity
      issue(1'b0, SZ_W, 32'h8000_0100, 32'h0);
      mem_uncached = 1'b0;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("cached_stall", 64'(dm_stall), 64'd0);
         chk("cached_req",   64'(bus.req),  64'd0);
         nxt();
      end
      drop();

      // Store half, addr_ok delayed three cycles
      issue(1'b1, SZ_H, 32'hBFD0_0020, 32'h0000_A5A5);
      push_req(1'b1, SZ_H, 32'hBFD0_0020, 32'h0000_A5A5);
      smp(); chk("t2_c0_stall", 64'(dm_stall), 64'd1);
      nxt();
      mem_addr = 32'h1234_5678; mem_wdata = 32'hFFFF_FFFF; mem_size = SZ_B;
      for (int i = 0; i < 4; i++) begin
         bus.addr_ok = (i == 3);
         smp();
         chk("t2_req",   64'(bus.req),   64'd1);
         chk("t2_wr",    64'(bus.wr),    64'd1);
         chk("t2_size",  64'(bus.size),  64'(SZ_H));
         chk("t2_addr",  64'(bus.addr),  64'h0000_0000_BFD0_0020);
         chk("t2_wdata", 64'(bus.wdata), 64'h0000_0000_0000_A5A5);
         chk("t2_stall", 64'(dm_stall),  64'd1);
         nxt();
      end
      bus.addr_ok = 1'b0;
      smp(); chk("t2_wait_stall", 64'(dm_stall), 64'd1); chk("t2_wait_req", 64'(bus.req), 64'd0);
      nxt();
      bus.data_ok = 1'b1;
      smp(); chk("t2_done_stall", 64'(dm_stall), 64'd0);
      nxt();
      drop();
      nxt();

      // Load completing while the pipe is held: DONE path
      issue(1'b0, SZ_W, 32'hBFD0_0030, 32'h0);
      push_req(1'b0, SZ_W, 32'hBFD0_0030, 32'h0);
      nxt();
      bus.addr_ok = 1'b1;
      nxt();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h1234_5678; pipe_ready = 1'b0;
      smp(); chk("t3_dok_stall", 64'(dm_stall), 64'd0); chk("t3_dok_rdata", 64'(mem_rdata), 64'h1234_5678);
      nxt();
      bus.data_ok = 1'b0; bus.rdata = 32'hAAAA_AAAA;
      smp();
      chk("t3_done_state", 64'(dut.state_q), 64'(S_DONE));
      chk("t3_done_stall", 64'(dm_stall), 64'd0);
      chk("t3_done_rdata", 64'(mem_rdata), 64'h1234_5678);
      chk("t3_done_req",   64'(bus.req), 64'd0);
      nxt();
      pipe_ready = 1'b1;
      exp_rd.push_back(32'h1234_5678);
      smp(); chk("t3_leave_req", 64'(bus.req), 64'd0);
      nxt();
      drop();
      smp(); chk("t3_idle_state", 64'(dut.state_q), 64'(S_IDLE)); chk("t3_idle_req", 64'(bus.req), 64'd0);
      nxt();

      // Flush during REQ before addr_ok: store never reaches the bus
      issue(1'b1, SZ_W, 32'hBFD0_0040, 32'h5555_5555);
      nxt();
      flush = 1'b1;
      smp(); chk("t4_flush_req", 64'(bus.req), 64'd1);
      nxt();
      flush = 1'b0; drop();
      smp();
      chk("t4_after_req",   64'(bus.req),  64'd0);
      chk("t4_after_stall", 64'(dm_stall), 64'd0);
      chk("t4_after_state", 64'(dut.state_q), 64'(S_IDLE));
      nxt();

      // Flush in WAIT, younger load waits in DRAIN
      issue(1'b0, SZ_W, 32'hBFD0_0050, 32'h0);
      push_req(1'b0, SZ_W, 32'hBFD0_0050, 32'h0);
      nxt();
      bus.addr_ok = 1'b1;
      nxt();
      bus.addr_ok = 1'b0; flush = 1'b1;
      nxt();
      flush = 1'b0;
      issue(1'b0, SZ_W, 32'hBFD0_0060, 32'h0);
      smp();
      chk("t5_drain_state", 64'(dut.state_q), 64'(S_DRAIN));
      chk("t5_drain_stall", 64'(dm_stall), 64'd1);
      chk("t5_drain_req",   64'(bus.req),  64'd0);
      nxt();
      bus.data_ok = 1'b1; bus.rdata = 32'h1111_1111;
      smp(); chk("t5_old_dok_stall", 64'(dm_stall), 64'd1); chk("t5_old_dok_req", 64'(bus.req), 64'd0);
      nxt();
      bus.data_ok = 1'b0;
      push_req(1'b0, SZ_W, 32'hBFD0_0060, 32'h0);
      smp(); chk("t5_idle_stall", 64'(dm_stall), 64'd1); chk("t5_idle_req", 64'(bus.req), 64'd0);
      nxt();
      bus.addr_ok = 1'b1;
      smp(); chk("t5_new_req", 64'(bus.req), 64'd1);
      nxt();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h2222_2222;
      exp_rd.push_back(32'h2222_2222);
      smp(); chk("t5_new_stall", 64'(dm_stall), 64'd0);
      nxt();
      drop();
      nxt();

      // Reset asserted during WAIT
      issue(1'b0, SZ_W, 32'hBFD0_0070, 32'h0);
      push_req(1'b0, SZ_W, 32'hBFD0_0070, 32'h0);
      nxt();
      bus.addr_ok = 1'b1;
      nxt();
      bus.addr_ok = 1'b0;
      resetn = 1'b0;
      #1;
      chk("t6_rst_req",   64'(bus.req),   64'd0);
      chk("t6_rst_stall", 64'(dm_stall),  64'd0);
      chk("t6_rst_rdata", 64'(mem_rdata), 64'd0);
      chk("t6_rst_state", 64'(dut.state_q), 64'(S_IDLE));
      nxt();
      resetn = 1'b1;
      push_req(1'b0, SZ_W, 32'hBFD0_0070, 32'h0);
      smp(); chk("t6_re_stall", 64'(dm_stall), 64'd1);
      nxt();
      bus.addr_ok = 1'b1;
      smp(); chk("t6_re_req", 64'(bus.req), 64'd1);
      nxt();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hCAFE_F00D;
      exp_rd.push_back(32'hCAFE_F00D);
      smp(); chk("t6_re_stall_dok", 64'(dm_stall), 64'd0);
      nxt();
      drop();
      smp(); chk("t6_end_state", 64'(dut.state_q), 64'(S_IDLE));
      nxt(); nxt();

      chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
      chk("exp_rd_drained",  64'(exp_rd.size()),  64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
